// File: rtl/dma_transmit_csr_if.sv
// dma_transmit_csr_if: Avalon-MM bus bundle between the host and the DMA transmit CSR block.
interface dma_transmit_csr_if #(parameter int ADDR_W = 3);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              readdatavalid;
    modport master (output address, read, write, writedata, input readdata, readdatavalid);
    modport slave  (input address, read, write, writedata, output readdata, readdatavalid);
endinterface

// File: rtl/dma_transmit_csr.sv
// dma_transmit_csr: per-channel enable/start/busy/done CSRs with masked irq and completion counter.
module dma_transmit_csr #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    dma_transmit_csr_if.slave   avs_s0,
    output logic [N_CH-1:0]     dma_transmit_on,
    output logic [N_CH-1:0]     dma_start,
    input  logic [N_CH-1:0]     dma_done,
    output logic                irq
);
    typedef enum logic [1:0] {IDLE, START, RUN} state_e;
    localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_START = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_BUSY  = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_DONE  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] A_IRQEN = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CNT   = ADDR_W'(5);

    state_e            state_q [N_CH];
    state_e            state_d [N_CH];
    logic [N_CH-1:0]   ctrl_q, ctrl_d, done_q, done_d, irq_en_q, irq_en_d, busy, acc;
    logic [CNT_W-1:0]  cnt_q, cnt_d, inc;
    logic [31:0]       rdata_q, rdata_d, rd_word;
    logic              rdv_q;
    logic [N_CH-1:0]   wd;
    logic              unused_wd_hi;

    assign wd           = avs_s0.writedata[N_CH-1:0];
    assign unused_wd_hi = ^avs_s0.writedata[31:N_CH];

    logic wr_ctrl, wr_start, wr_done, wr_irqen, wr_cnt;
    assign wr_ctrl  = avs_s0.write && avs_s0.address == A_CTRL;
    assign wr_start = avs_s0.write && avs_s0.address == A_START;
    assign wr_done  = avs_s0.write && avs_s0.address == A_DONE;
    assign wr_irqen = avs_s0.write && avs_s0.address == A_IRQEN;
    assign wr_cnt   = avs_s0.write && avs_s0.address == A_CNT;

    always_comb begin
        busy      = '0;
        acc       = '0;
        dma_start = '0;
        inc       = '0;
        for (int i = 0; i < N_CH; i++) begin
            busy[i]      = state_q[i] != IDLE;
            dma_start[i] = state_q[i] == START;
            acc[i]       = state_q[i] == RUN && dma_done[i];
            inc          = inc + CNT_W'(acc[i]);
            // CTRL is sampled from the register, so a same-cycle CTRL write does not gate this start
            state_d[i]   = (state_q[i] == IDLE && wr_start && wd[i] && ctrl_q[i]) ? START :
                           state_q[i] == START ? RUN :
                           acc[i] ? IDLE : state_q[i];
        end
        ctrl_d   = wr_ctrl ? wd : ctrl_q;
        irq_en_d = wr_irqen ? wd : irq_en_q;
        done_d   = (done_q & ~(wr_done ? wd : '0)) | acc;
        cnt_d    = (wr_cnt ? '0 : cnt_q) + inc;
        rd_word  = avs_s0.address == A_CTRL  ? 32'(ctrl_q)   :
                   avs_s0.address == A_BUSY  ? 32'(busy)     :
                   avs_s0.address == A_DONE  ? 32'(done_q)   :
                   avs_s0.address == A_IRQEN ? 32'(irq_en_q) :
                   avs_s0.address == A_CNT   ? 32'(cnt_q)    : '0;
        rdata_d  = avs_s0.read ? rd_word : rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= '{default: IDLE};
            ctrl_q   <= '0;
            done_q   <= '0;
            irq_en_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rdv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rdv_q    <= avs_s0.read;
        end
    end

    assign avs_s0.readdata      = rdata_q;
    assign avs_s0.readdatavalid = rdv_q;
    assign dma_transmit_on      = ctrl_q;
    assign irq                  = |(done_q & irq_en_q);
endmodule

// File: tb/tb_dma_transmit_csr.sv
// tb_dma_transmit_csr: directed test of the DMA transmit CSR block with hand-computed expectations.
module tb_dma_transmit_csr;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] dma_transmit_on, dma_start, dma_done;
    logic       irq;
    int         checks = 0;
    int         errors = 0;

    dma_transmit_csr_if #(.ADDR_W(3)) avs_s0 ();

    dma_transmit_csr #(.N_CH(4), .CNT_W(4), .ADDR_W(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .avs_s0          (avs_s0.slave),
        .dma_transmit_on (dma_transmit_on),
        .dma_start       (dma_start),
        .dma_done        (dma_done),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_s0.address   = a;
        avs_s0.writedata = d;
        avs_s0.write     = 1'b1;
        tick();
        avs_s0.write     = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string tag);
        avs_s0.address = a;
        avs_s0.read    = 1'b1;
        tick();
        avs_s0.read    = 1'b0;
        check({tag, "_rdv"}, 32'(avs_s0.readdatavalid), 32'd1);
        check(tag, avs_s0.readdata, exp);
    endtask

    task automatic complete(input logic [3:0] ch);
        bus_write(3'd1, 32'(ch));
        tick();
        dma_done = ch;
        tick();
        dma_done = '0;
    endtask

    initial begin
        avs_s0.address   = '0;
        avs_s0.read      = 1'b0;
        avs_s0.write     = 1'b0;
        avs_s0.writedata = '0;
        dma_done         = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_start", 32'(dma_start), 32'd0);
        check("rst_on", 32'(dma_transmit_on), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdv", 32'(avs_s0.readdatavalid), 32'd0);
        for (int a = 0; a < 8; a++) bus_read(3'(a), 32'd0, "rst_read");
        tick();
        check("rdv_one_cycle", 32'(avs_s0.readdatavalid), 32'd0);
        check("rdata_hold", avs_s0.readdata, 32'd0);

        // read and write CTRL together: read sees the pre-write value
        avs_s0.address   = 3'd0;
        avs_s0.writedata = 32'h5;
        avs_s0.read      = 1'b1;
        avs_s0.write     = 1'b1;
        tick();
        avs_s0.read      = 1'b0;
        avs_s0.write     = 1'b0;
        check("rw_old_data", avs_s0.readdata, 32'd0);
        check("on_after_ctrl", 32'(dma_transmit_on), 32'h5);
        bus_read(3'd0, 32'h5, "ctrl_rb");

        bus_write(3'd1, 32'hF);
        check("start_pulse", 32'(dma_start), 32'h5);
        tick();
        check("start_one_cycle", 32'(dma_start), 32'h0);
        bus_read(3'd2, 32'h5, "busy_run");
        bus_read(3'd1, 32'h0, "start_reads0");

        dma_done = 4'h5;
        tick();
        dma_done = '0;
        bus_read(3'd2, 32'h0, "busy_idle");
        bus_read(3'd3, 32'h5, "done_set");
        bus_read(3'd5, 32'h2, "count2");
        bus_write(3'd4, 32'h4);
        check("irq_on", 32'(irq), 32'd1);
        bus_write(3'd3, 32'h4);
        check("irq_off", 32'(irq), 32'd0);
        bus_read(3'd3, 32'h1, "done_w1c");

        bus_write(3'd1, 32'h1);
        check("restart_pulse", 32'(dma_start), 32'h1);
        tick();
        bus_write(3'd1, 32'h1);
        check("no_pulse_in_run", 32'(dma_start), 32'h0);
        dma_done = 4'h2;
        tick();
        dma_done = '0;
        bus_read(3'd3, 32'h1, "idle_done_ignored");
        bus_read(3'd5, 32'h2, "idle_count_same");

        dma_done         = 4'h1;
        avs_s0.address   = 3'd3;
        avs_s0.writedata = 32'h1;
        avs_s0.write     = 1'b1;
        tick();
        avs_s0.write     = 1'b0;
        dma_done         = '0;
        bus_read(3'd3, 32'h1, "set_beats_w1c");
        bus_read(3'd5, 32'h3, "count3");

        bus_write(3'd1, 32'h5);
        tick();
        bus_write(3'd0, 32'h0);
        bus_read(3'd2, 32'h5, "busy_ctrl_off");
        dma_done         = 4'h5;
        avs_s0.address   = 3'd5;
        avs_s0.writedata = 32'h0;
        avs_s0.write     = 1'b1;
        tick();
        avs_s0.write     = 1'b0;
        dma_done         = '0;
        bus_read(3'd5, 32'h2, "clr_plus_inc");
        bus_read(3'd3, 32'h5, "done_after_ctrl_off");
        bus_write(3'd1, 32'h1);
        check("start_ctrl_off", 32'(dma_start), 32'h0);
        bus_read(3'd2, 32'h0, "busy_ctrl_off_idle");

        bus_write(3'd0, 32'h1);
        bus_write(3'd5, 32'h0);
        for (int n = 0; n < 15; n++) complete(4'h1);
        bus_read(3'd5, 32'hF, "count15");
        complete(4'h1);
        bus_read(3'd5, 32'h0, "count_wrap");

        bus_write(3'd0, 32'h5);
        bus_write(3'd4, 32'hF);
        bus_write(3'd1, 32'h5);
        check("pre_reset_pulse", 32'(dma_start), 32'h5);
        reset = 1'b1;
        #1;
        check("async_start", 32'(dma_start), 32'h0);
        check("async_on", 32'(dma_transmit_on), 32'h0);
        dma_done = 4'h5;
        tick();
        tick();
        reset    = 1'b0;
        dma_done = '0;
        check("post_rst_irq", 32'(irq), 32'd0);
        bus_read(3'd2, 32'h0, "post_rst_busy");
        bus_read(3'd3, 32'h0, "post_rst_done");
        bus_read(3'd5, 32'h0, "post_rst_count");
        bus_read(3'd4, 32'h0, "post_rst_irqen");
        check("post_rst_start", 32'(dma_start), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
